inert_intf_ctrl: RTL

- Command sequencer directly upstream of SPI_mnrch.
- After power-up it writes the iNEMO configuration registers.
- On each rising INT from the sensor it reads pitch/roll/yaw rate low/high bytes through SPI_mnrch and assembles 16-bit signed readings with a one-cycle valid strobe.
- Only client of SPI_mnrch's wrt/wt_data/done/rd_data.

---
 rtl/inert_pkg.sv | 50 +++++
 rtl/inert_int_sync.sv | 25 ++
 rtl/inert_intf_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/inert_pkg.sv
// Shared types and command tables for the iNEMO interface sequencer.
package inert_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CFG_WRT,
    ST_CFG_WAIT,
    ST_IDLE,
    ST_RD_WRT,
    ST_RD_WAIT,
    ST_UPDATE
  } inert_state_t;

  localparam int   NUM_CFG  = 4;
  localparam int   NUM_RD   = 6;
  localparam logic READ_BIT = 1'b1;

  // Config writes: INT on data-ready, accel 416Hz, gyro 416Hz, rounding.
  function automatic logic [15:0] cfg_cmd(input logic [2:0] idx);
    logic [15:0] cmd;
    case (idx)
      3'd0:    cmd = 16'h0D02;
      3'd1:    cmd = 16'h1062;
      3'd2:    cmd = 16'h1162;
      3'd3:    cmd = 16'h1460;
      default: cmd = 16'h0000;
    endcase
    return cmd;
  endfunction

  // Rate registers in pitch L/H, roll L/H, yaw L/H order.
  function automatic logic [6:0] raddr(input logic [2:0] idx);
    logic [6:0] a;
    case (idx)
      3'd0:    a = 7'h22;
      3'd1:    a = 7'h23;
      3'd2:    a = 7'h24;
      3'd3:    a = 7'h25;
      3'd4:    a = 7'h26;
      3'd5:    a = 7'h27;
      default: a = 7'h00;
    endcase
    return a;
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [2:0] idx);
    return {READ_BIT, raddr(idx), 8'h00};
  endfunction

endpackage

// File: rtl/inert_int_sync.sv
// Brings the asynchronous sensor INT into the clk domain and flags its rising edge.
module inert_int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic INT,
  output logic int_rise
);

  logic r_ff1, r_ff2, r_ff3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
      r_ff3 <= 1'b0;
    end else begin
      r_ff1 <= INT;
      r_ff2 <= r_ff1;
      r_ff3 <= r_ff2;
    end
  end

  assign int_rise = r_ff2 & ~r_ff3;

endmodule

// File: rtl/inert_intf_ctrl.sv
// Command sequencer in front of SPI_mnrch: configures the iNEMO, then reads rates on INT.
// Build option INERT_FAST_SIM_EN shortens the power-up wait to 511 cycles.
module inert_intf_ctrl
  import inert_pkg::*;
#(
  parameter int STARTUP_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        wt_data,
  output logic               init_done,
  output logic               vld,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] roll_rt,
  output logic signed [15:0] yaw_rt
);

  inert_state_t          r_state, w_nxt_state;
  logic [STARTUP_W-1:0]  r_cnt;
  logic [2:0]            r_idx, w_nxt_idx;
  logic [15:0]           r_wt_data, w_nxt_wt_data;
  logic                  r_pend, r_init_done, r_vld;
  logic [7:0]            r_byte [0:NUM_RD-1];
  logic signed [15:0]    r_ptch, r_roll, r_yaw;
  logic                  w_int_rise, w_cnt_full;
  logic                  w_set_init, w_clr_pend, w_cap;

  inert_int_sync u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .INT      (INT),
    .int_rise (w_int_rise)
  );

`ifdef INERT_FAST_SIM_EN
  assign w_cnt_full = &r_cnt[8:0];
`else
  assign w_cnt_full = &r_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_idx       <= 3'd0;
      r_wt_data   <= 16'h0000;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_idx     <= w_nxt_idx;
      r_wt_data <= w_nxt_wt_data;
      if (r_state == ST_INIT)
        r_cnt <= r_cnt + 1'b1;
      if (w_set_init)
        r_init_done <= 1'b1;
    end
  end

  // Command word is loaded on entry to a WRT state so it is stable while wrt is high.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_idx     = r_idx;
    w_nxt_wt_data = r_wt_data;
    w_set_init    = 1'b0;
    w_clr_pend    = 1'b0;
    w_cap         = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_cnt_full) begin
          w_nxt_state   = ST_CFG_WRT;
          w_nxt_idx     = 3'd0;
          w_nxt_wt_data = cfg_cmd(3'd0);
        end
      end
      ST_CFG_WRT: w_nxt_state = ST_CFG_WAIT;
      ST_CFG_WAIT: begin
        if (done) begin
          if (r_idx == 3'(NUM_CFG - 1)) begin
            w_set_init  = 1'b1;
            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_idx     = r_idx + 3'd1;
            w_nxt_wt_data = cfg_cmd(r_idx + 3'd1);
            w_nxt_state   = ST_CFG_WRT;
          end
        end
      end
      ST_IDLE: begin
        if (w_int_rise || r_pend) begin
          w_clr_pend    = 1'b1;
          w_nxt_idx     = 3'd0;
          w_nxt_wt_data = rd_cmd(3'd0);
          w_nxt_state   = ST_RD_WRT;
        end
      end
      ST_RD_WRT: w_nxt_state = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (done) begin
          w_cap = 1'b1;
          if (r_idx == 3'(NUM_RD - 1)) begin
            w_nxt_state = ST_UPDATE;
          end else begin
            w_nxt_idx     = r_idx + 3'd1;
            w_nxt_wt_data = rd_cmd(r_idx + 3'd1);
            w_nxt_state   = ST_RD_WRT;
          end
        end
      end
      ST_UPDATE: w_nxt_state = ST_IDLE;
      default:   w_nxt_state = ST_INIT;
    endcase
  end

  // A rise arriving mid-burst is remembered; rises before init completes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pend <= 1'b0;
    else if (w_clr_pend)
      r_pend <= 1'b0;
    else if (w_int_rise && r_init_done)
      r_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RD; i++)
        r_byte[i] <= 8'h00;
    end else if (w_cap) begin
      r_byte[r_idx] <= rd_data[7:0];
    end
  end

  // All three rates and vld change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptch <= 16'sd0;
      r_roll <= 16'sd0;
      r_yaw  <= 16'sd0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= (r_state == ST_UPDATE);
      if (r_state == ST_UPDATE) begin
        r_ptch <= {r_byte[1], r_byte[0]};
        r_roll <= {r_byte[3], r_byte[2]};
        r_yaw  <= {r_byte[5], r_byte[4]};
      end
    end
  end

  assign wrt       = (r_state == ST_CFG_WRT) || (r_state == ST_RD_WRT);
  assign wt_data   = r_wt_data;
  assign init_done = r_init_done;
  assign vld       = r_vld;
  assign ptch_rt   = r_ptch;
  assign roll_rt   = r_roll;
  assign yaw_rt    = r_yaw;

endmodule
